// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: fetches an opcode over a ready handshake, decodes it
// into the 9-bit control word and sequences FETCH/DECODE/EXEC/MEM/WB with phase-exact strobes.
module multicycle_control_unit #(
  parameter bit EN_BRANCH = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic [8:0]       con_signals,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write_en,
  output logic             mem_write_en,
  output logic             uncond,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_LD  = 3'd1;
  localparam logic [2:0] K_ST  = 3'd2;
  localparam logic [2:0] K_CBZ = 3'd3;
  localparam logic [2:0] K_B   = 3'd4;
  localparam logic [2:0] K_ILL = 3'd5;

  // Control word: {Reg2Loc, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
  localparam logic [8:0] CON_R   = 9'b000010001;
  localparam logic [8:0] CON_LD  = 9'b001100011;
  localparam logic [8:0] CON_ST  = 9'b100000110;
  localparam logic [8:0] CON_CBZ = 9'b110001000;
  localparam logic [8:0] CON_B   = 9'b010000000;

  logic [2:0]       state_q, state_d;
  logic [10:0]      opcode_q, opcode_d;
  logic [2:0]       kind_q, kind_d;
  logic [8:0]       con_q, con_d;
  logic             uncond_q, uncond_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] dec_kind;
  logic [8:0] dec_con;
  logic       retire;
  logic       imem_req_c, dmem_req_c, ir_write_c, pc_write_c, reg_write_c, mem_write_c;

  always_comb begin
    dec_kind = K_ILL;
    dec_con  = '0;
    casez (opcode_q)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: begin
        dec_kind = K_R;
        dec_con  = CON_R;
      end
      11'b11111000010: begin
        dec_kind = K_LD;
        dec_con  = CON_LD;
      end
      11'b11111000000: begin
        dec_kind = K_ST;
        dec_con  = CON_ST;
      end
      11'b10110100???: begin
        if (EN_BRANCH) begin
          dec_kind = K_CBZ;
          dec_con  = CON_CBZ;
        end
      end
      11'b000101?????: begin
        if (EN_BRANCH) begin
          dec_kind = K_B;
          dec_con  = CON_B;
        end
      end
      default: begin
        dec_kind = K_ILL;
        dec_con  = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    kind_d      = kind_q;
    con_d       = con_q;
    uncond_d    = uncond_q;
    retired_d   = retired_q;
    retire      = 1'b0;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          opcode_d   = opcode;
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        kind_d   = dec_kind;
        con_d    = dec_con;
        uncond_d = (dec_kind == K_B);
        state_d  = (dec_kind == K_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (kind_q)
          K_R:        state_d = S_WB;
          K_LD, K_ST: state_d = S_MEM;
          K_CBZ: begin
            pc_write_c = zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          K_B: begin
            pc_write_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req_c  = 1'b1;
        mem_write_c = con_q[2] && dmem_ready;
        if (dmem_ready) begin
          if (kind_q == K_LD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_c = con_q[0];
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      // Unused encodings can only come from an upset; park them like an illegal opcode
      default: state_d = S_TRAP;
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      kind_q    <= K_R;
      con_q     <= '0;
      uncond_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      kind_q    <= kind_d;
      con_q     <= con_d;
      uncond_q  <= uncond_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are combinational in their phase, so a reset cycle must mask them explicitly
  assign imem_req     = imem_req_c  & ~reset;
  assign dmem_req     = dmem_req_c  & ~reset;
  assign ir_write     = ir_write_c  & ~reset;
  assign pc_write     = pc_write_c  & ~reset;
  assign reg_write_en = reg_write_c & ~reset;
  assign mem_write_en = mem_write_c & ~reset;

  assign con_signals = con_q;
  assign uncond      = uncond_q;
  assign illegal     = (state_q == S_TRAP);
  assign retired     = retired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a branch-enabled 16-bit-counter instance and a
// branch-disabled 2-bit-counter instance share stimulus and are checked against a route model.
module tb_multicycle_control_unit;

  localparam logic [10:0] ADD_OP  = 11'b10001011000;
  localparam logic [10:0] SUB_OP  = 11'b11001011000;
  localparam logic [10:0] AND_OP  = 11'b10001010000;
  localparam logic [10:0] ORR_OP  = 11'b10101010000;
  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;
  localparam logic [10:0] CBZ1_OP = 11'b10110100101;
  localparam logic [10:0] CBZ0_OP = 11'b10110100000;
  localparam logic [10:0] B_OP    = 11'b00010111111;
  localparam logic [10:0] BAD_OP  = 11'b11111111111;

  localparam logic [8:0] CR = 9'b000010001;
  localparam logic [8:0] CL = 9'b001100011;
  localparam logic [8:0] CS = 9'b100000110;
  localparam logic [8:0] CC = 9'b110001000;
  localparam logic [8:0] CB = 9'b010000000;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        imem_ready, dmem_ready, zero;

  logic [8:0]  a_con, b_con;
  logic        a_imem_req, a_dmem_req, a_ir_write, a_pc_write, a_reg_we, a_mem_we, a_uncond, a_illegal;
  logic        b_imem_req, b_dmem_req, b_ir_write, b_pc_write, b_reg_we, b_mem_we, b_uncond, b_illegal;
  logic [15:0] a_retired;
  logic [1:0]  b_retired;
  logic [2:0]  a_state, b_state;
  logic [35:0] a_vec, b_vec;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // Model: each instruction walks a route of phases; position advances unless the phase waits
  int          m_pos[2];
  bit          m_trap[2];
  logic [8:0]  m_ctl[2];
  bit          m_unc[2];
  int          m_ret[2];
  int          m_kind[2];
  logic [10:0] m_op[2];
  bit          en_cfg[2] = '{1'b1, 1'b0};
  int          cw_cfg[2] = '{16, 2};

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        ir;
    logic        dr;
    logic        z;
    logic [2:0]  st;
    logic [8:0]  con;
    logic [7:0]  strb;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];
  int   exp_cnt2[5] = '{1, 2, 3, 0, 1};

  multicycle_control_unit #(.EN_BRANCH(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .con_signals(a_con), .imem_req(a_imem_req),
    .dmem_req(a_dmem_req), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .reg_write_en(a_reg_we), .mem_write_en(a_mem_we), .uncond(a_uncond),
    .illegal(a_illegal), .retired(a_retired), .state(a_state)
  );

  multicycle_control_unit #(.EN_BRANCH(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .con_signals(b_con), .imem_req(b_imem_req),
    .dmem_req(b_dmem_req), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .reg_write_en(b_reg_we), .mem_write_en(b_mem_we), .uncond(b_uncond),
    .illegal(b_illegal), .retired(b_retired), .state(b_state)
  );

  assign a_vec = {a_state, a_con, a_imem_req, a_dmem_req, a_ir_write, a_pc_write,
                  a_reg_we, a_mem_we, a_uncond, a_illegal, a_retired};
  assign b_vec = {b_state, b_con, b_imem_req, b_dmem_req, b_ir_write, b_pc_write,
                  b_reg_we, b_mem_we, b_uncond, b_illegal, 14'd0, b_retired};

  initial forever #5 clk = ~clk;

  function automatic int classify(logic [10:0] op, bit en);
    if (op == ADD_OP || op == SUB_OP || op == AND_OP || op == ORR_OP) return K_R;
    if (op == LDUR_OP) return K_LD;
    if (op == STUR_OP) return K_ST;
    if ((op >> 3) == 11'b00010110100) return en ? K_CBZ : K_ILL;
    if ((op >> 5) == 11'b00000000101) return en ? K_B : K_ILL;
    return K_ILL;
  endfunction

  function automatic logic [8:0] ctl_of(int kind);
    case (kind)
      K_R:     return CR;
      K_LD:    return CL;
      K_ST:    return CS;
      K_CBZ:   return CC;
      K_B:     return CB;
      default: return 9'd0;
    endcase
  endfunction

  function automatic int route_len(int kind);
    case (kind)
      K_LD:     return 5;
      K_R, K_ST: return 4;
      default:  return 3;
    endcase
  endfunction

  // Routes: R = F,D,E,WB   LD = F,D,E,MEM,WB   ST = F,D,E,MEM   CBZ/B = F,D,E
  function automatic int route_phase(int kind, int pos);
    if (pos < 3) return pos;
    if (pos == 3) return (kind == K_R) ? 4 : 3;
    return 4;
  endfunction

  function automatic logic [35:0] model_expect(int k, logic rst, logic ir, logic dr, logic z);
    int ph;
    logic [7:0] s;
    ph = m_trap[k] ? 7 : route_phase(m_kind[k], m_pos[k]);
    s = '0;
    if (!rst) begin
      s[7] = (ph == 0);
      s[6] = (ph == 3);
      s[5] = (ph == 0) && ir;
      s[4] = ((ph == 0) && ir) || ((ph == 2) && (m_kind[k] == K_B || (m_kind[k] == K_CBZ && z)));
      s[3] = (ph == 4);
      s[2] = (ph == 3) && dr && (m_kind[k] == K_ST);
    end
    s[1] = m_unc[k];
    s[0] = m_trap[k];
    return {3'(ph), m_ctl[k], s, 16'(m_ret[k])};
  endfunction

  task automatic model_advance(int k);
    int ph;
    if (reset) begin
      m_pos[k] = 0; m_trap[k] = 1'b0; m_ctl[k] = '0; m_unc[k] = 1'b0;
      m_ret[k] = 0; m_kind[k] = K_R;
      return;
    end
    if (m_trap[k]) return;
    ph = route_phase(m_kind[k], m_pos[k]);
    if (ph == 0) begin
      if (imem_ready) begin
        m_op[k]  = opcode;
        m_pos[k] = 1;
      end
    end else if (ph == 1) begin
      m_kind[k] = classify(m_op[k], en_cfg[k]);
      m_trap[k] = (m_kind[k] == K_ILL);
      m_ctl[k]  = ctl_of(m_kind[k]);
      m_unc[k]  = (m_kind[k] == K_B);
      m_pos[k]  = 2;
    end else if (!(ph == 3 && !dmem_ready)) begin
      m_pos[k]++;
      if (m_pos[k] == route_len(m_kind[k])) begin
        m_pos[k] = 0;
        m_ret[k] = (m_ret[k] + 1) % (1 << cw_cfg[k]);
      end
    end
  endtask

  task automatic checkOutput(string name, logic [35:0] act, logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d con=%b strb=%b retired=%0d, want state=%0d con=%b strb=%b retired=%0d",
               name, act[35:33], act[32:24], act[23:16], act[15:0],
               exp[35:33], exp[32:24], exp[23:16], exp[15:0]);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drives inputs just after an edge and samples outputs just before the next one
  task automatic applyStimulus(logic r, logic [10:0] op, logic i, logic d, logic z);
    reset = r; opcode = op; imem_ready = i; dmem_ready = d; zero = z;
    #3;
    if (checking) begin
      checkOutput("model_a", a_vec, model_expect(0, r, i, d, z));
      checkOutput("model_b", b_vec, model_expect(1, r, i, d, z));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance(0);
    model_advance(1);
    #1;
  endtask

  task automatic step(logic r, logic [10:0] op, logic i, logic d, logic z);
    applyStimulus(r, op, i, d, z);
    tick();
  endtask

  function automatic vec_t mk(logic r, logic [10:0] op, logic i, logic d, logic z,
                              logic [2:0] st, logic [8:0] con, logic [7:0] strb, logic [15:0] ret);
    vec_t v;
    v.rst = r; v.op = op; v.ir = i; v.dr = d; v.z = z;
    v.st = st; v.con = con; v.strb = strb; v.ret = ret;
    return v;
  endfunction

  function automatic logic [10:0] rand_op();
    logic [10:0] r;
    r = 11'($urandom);
    case ($urandom_range(0, 9))
      0: return ADD_OP;
      1: return SUB_OP;
      2: return AND_OP;
      3: return ORR_OP;
      4: return LDUR_OP;
      5: return STUR_OP;
      6: return {8'b10110100, r[2:0]};
      7: return {6'b000101, r[4:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_trap[k] = 1'b0; m_ctl[k] = '0; m_unc[k] = 1'b0;
      m_ret[k] = 0; m_kind[k] = K_R; m_op[k] = '0;
    end
    applyStimulus(1'b1, ADD_OP, 1'b0, 1'b0, 1'b0);
    tick();
    checking = 1'b1;

    // strb = {imem_req, dmem_req, ir_write, pc_write, reg_write_en, mem_write_en, uncond, illegal}
    tbl.push_back(mk(1, ADD_OP,  0, 0, 0, 3'd0, 9'd0, 8'b00000000, 16'd0));
    tbl.push_back(mk(0, ADD_OP,  1, 0, 0, 3'd0, 9'd0, 8'b10110000, 16'd0));
    tbl.push_back(mk(0, BAD_OP,  0, 0, 0, 3'd1, 9'd0, 8'b00000000, 16'd0));
    tbl.push_back(mk(0, BAD_OP,  1, 1, 0, 3'd2, CR,   8'b00000000, 16'd0));
    tbl.push_back(mk(0, BAD_OP,  0, 0, 0, 3'd4, CR,   8'b00001000, 16'd0));
    tbl.push_back(mk(0, LDUR_OP, 1, 0, 0, 3'd0, CR,   8'b10110000, 16'd1));
    tbl.push_back(mk(0, LDUR_OP, 0, 0, 0, 3'd1, CR,   8'b00000000, 16'd1));
    tbl.push_back(mk(0, LDUR_OP, 0, 0, 0, 3'd2, CL,   8'b00000000, 16'd1));
    tbl.push_back(mk(0, ADD_OP,  0, 0, 0, 3'd3, CL,   8'b01000000, 16'd1));
    tbl.push_back(mk(0, ADD_OP,  0, 0, 0, 3'd3, CL,   8'b01000000, 16'd1));
    tbl.push_back(mk(0, ADD_OP,  0, 0, 0, 3'd3, CL,   8'b01000000, 16'd1));
    tbl.push_back(mk(0, ADD_OP,  0, 1, 0, 3'd3, CL,   8'b01000000, 16'd1));
    tbl.push_back(mk(0, ADD_OP,  0, 1, 0, 3'd4, CL,   8'b00001000, 16'd1));
    tbl.push_back(mk(0, STUR_OP, 1, 1, 0, 3'd0, CL,   8'b10110000, 16'd2));
    tbl.push_back(mk(0, STUR_OP, 1, 0, 0, 3'd1, CL,   8'b00000000, 16'd2));
    tbl.push_back(mk(0, STUR_OP, 0, 0, 1, 3'd2, CS,   8'b00000000, 16'd2));
    tbl.push_back(mk(0, STUR_OP, 0, 0, 0, 3'd3, CS,   8'b01000000, 16'd2));
    tbl.push_back(mk(0, STUR_OP, 0, 1, 0, 3'd3, CS,   8'b01000100, 16'd2));
    tbl.push_back(mk(0, CBZ1_OP, 1, 0, 0, 3'd0, CS,   8'b10110000, 16'd3));
    tbl.push_back(mk(0, CBZ1_OP, 0, 0, 0, 3'd1, CS,   8'b00000000, 16'd3));
    tbl.push_back(mk(0, CBZ1_OP, 0, 0, 1, 3'd2, CC,   8'b00010000, 16'd3));
    tbl.push_back(mk(0, CBZ0_OP, 1, 0, 1, 3'd0, CC,   8'b10110000, 16'd4));
    tbl.push_back(mk(0, CBZ0_OP, 0, 0, 1, 3'd1, CC,   8'b00000000, 16'd4));
    tbl.push_back(mk(0, CBZ0_OP, 0, 0, 0, 3'd2, CC,   8'b00000000, 16'd4));
    tbl.push_back(mk(0, B_OP,    1, 0, 0, 3'd0, CC,   8'b10110000, 16'd5));
    tbl.push_back(mk(0, B_OP,    0, 0, 0, 3'd1, CC,   8'b00000000, 16'd5));
    tbl.push_back(mk(0, B_OP,    0, 0, 0, 3'd2, CB,   8'b00010010, 16'd5));
    tbl.push_back(mk(0, BAD_OP,  1, 0, 0, 3'd0, CB,   8'b10110010, 16'd6));
    tbl.push_back(mk(0, BAD_OP,  0, 0, 0, 3'd1, CB,   8'b00000010, 16'd6));
    tbl.push_back(mk(0, BAD_OP,  1, 1, 1, 3'd7, 9'd0, 8'b00000001, 16'd6));
    tbl.push_back(mk(0, BAD_OP,  0, 1, 0, 3'd7, 9'd0, 8'b00000001, 16'd6));
    tbl.push_back(mk(0, ADD_OP,  1, 0, 0, 3'd7, 9'd0, 8'b00000001, 16'd6));
    tbl.push_back(mk(1, ADD_OP,  1, 1, 0, 3'd7, 9'd0, 8'b00000001, 16'd6));
    tbl.push_back(mk(0, ADD_OP,  0, 0, 0, 3'd0, 9'd0, 8'b10000000, 16'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].op, tbl[i].ir, tbl[i].dr, tbl[i].z);
      checkOutput($sformatf("vec%0d", i), a_vec,
                  {tbl[i].st, tbl[i].con, tbl[i].strb, tbl[i].ret});
      tick();
    end

    // Five ADDs: the 2-bit counter must wrap through 0
    step(1'b1, ADD_OP, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, ADD_OP, 1'b1, 1'b0, 1'b0);
      step(1'b0, ADD_OP, 1'b0, 1'b0, 1'b0);
      step(1'b0, ADD_OP, 1'b0, 1'b0, 1'b0);
      step(1'b0, ADD_OP, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, ADD_OP, 1'b0, 1'b0, 1'b0);
      checkValue($sformatf("cnt2_retired%0d", i), int'(b_retired), exp_cnt2[i]);
      checkValue($sformatf("cnt16_retired%0d", i), int'(a_retired), i + 1);
      tick();
    end

    // Reset lands while a STUR waits in MEM
    step(1'b0, STUR_OP, 1'b1, 1'b0, 1'b0);
    step(1'b0, STUR_OP, 1'b0, 1'b0, 1'b0);
    step(1'b0, STUR_OP, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, STUR_OP, 1'b0, 1'b0, 1'b0);
    checkValue("stur_waits_in_mem", int'(a_state), 3);
    tick();
    applyStimulus(1'b1, STUR_OP, 1'b0, 1'b1, 1'b0);
    checkValue("reset_cycle_mem_we", int'(a_mem_we), 0);
    checkValue("reset_cycle_dmem_req", int'(a_dmem_req), 0);
    tick();
    applyStimulus(1'b0, STUR_OP, 1'b0, 1'b1, 1'b0);
    checkValue("after_reset_state", int'(a_state), 0);
    checkValue("after_reset_retired", int'(a_retired), 0);
    checkValue("after_reset_mem_we", int'(a_mem_we), 0);
    tick();

    // CBZ: executes with branches enabled, traps with them disabled
    step(1'b0, CBZ1_OP, 1'b1, 1'b0, 1'b0);
    step(1'b0, CBZ1_OP, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, CBZ1_OP, 1'b0, 1'b0, 1'b1);
    checkValue("nobranch_cbz_state", int'(b_state), 7);
    checkValue("nobranch_cbz_illegal", int'(b_illegal), 1);
    checkValue("branch_cbz_state", int'(a_state), 2);
    checkValue("branch_cbz_pc_write", int'(a_pc_write), 1);
    tick();
    step(1'b1, ADD_OP, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 39) == 0), rand_op(),
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
